// File: rtl/replica_pkg.sv
// Shared types for the replica node array command path: the distance
// command bundle, the sequencer state encoding, the phase counter width and
// the two helpers that describe the phase order and phase lengths.
package replica_pkg;

    localparam int PHASE_CNT_W = 8;

    typedef logic [PHASE_CNT_W-1:0] phase_cnt_t;

    typedef struct packed {
        logic init;
        logic run;
    } distance_command_t;

    typedef enum logic [3:0] {
        IDLE,
        RAND,
        OR_DIST,
        OR_EXP,
        OR_METRO,
        OR_REPL,
        OR_EXCH,
        TW_DIST,
        TW_EXP,
        TW_METRO,
        TW_REPL,
        TW_EXCH,
        NEXT
    } seq_state_t;

    // Fixed phase order within one iteration. NEXT and IDLE are resolved by
    // the sequencer itself because their successor depends on run status.
    function automatic seq_state_t seq_next(input seq_state_t s);
        seq_state_t n;
        n = IDLE;
        case (s)
            RAND:     n = OR_DIST;
            OR_DIST:  n = OR_EXP;
            OR_EXP:   n = OR_METRO;
            OR_METRO: n = OR_REPL;
            OR_REPL:  n = OR_EXCH;
            OR_EXCH:  n = TW_DIST;
            TW_DIST:  n = TW_EXP;
            TW_EXP:   n = TW_METRO;
            TW_METRO: n = TW_REPL;
            TW_REPL:  n = TW_EXCH;
            TW_EXCH:  n = NEXT;
            default:  n = IDLE;
        endcase
        return n;
    endfunction

    // Phase length minus one, the value loaded into the phase timer on entry.
    // RAND takes two cycles: a lead-in cycle, then the random_run strobe.
    function automatic phase_cnt_t phase_len_m1(input seq_state_t  s,
                                                input int unsigned dist_cyc,
                                                input int unsigned exp_cyc,
                                                input int unsigned exch_cyc);
        phase_cnt_t v;
        v = '0;
        case (s)
            RAND:             v = phase_cnt_t'(1);
            OR_DIST, TW_DIST: v = phase_cnt_t'(dist_cyc - 1);
            OR_EXP,  TW_EXP:  v = phase_cnt_t'(exp_cyc - 1);
            OR_EXCH, TW_EXCH: v = phase_cnt_t'(exch_cyc - 1);
            default:          v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/anneal_sequencer_phase_timer.sv
// phase_timer: loadable down-counter shared by every sequencer phase.
// Loaded with (length - 1) on phase entry; expire is high while it reads 0.
module phase_timer
    import replica_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  phase_cnt_t value,
    output logic       expire
);

    phase_cnt_t count;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // updates from pre-edge values, independent of statement order.
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - phase_cnt_t'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/anneal_sequencer.sv
// anneal_sequencer: command generator for the replica node array. Steps one
// annealing iteration at a time (random draw, or-opt half, two-opt half),
// drives the broadcast strobes, flips exchange_bank each iteration and
// reports progress. All outputs are registered.
// Optional feature macro: REPLICA_INTERVAL_EN (replica test only every
// 2^replica_interval iterations); default build runs it every iteration.
module anneal_sequencer
    import replica_pkg::*;
#(
    parameter int unsigned DIST_CYC = 4,
    parameter int unsigned EXP_CYC  = 3,
    parameter int unsigned EXCH_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       iter_num,
    input  logic [3:0]        replica_interval,
    output logic              busy,
    output logic              done,
    output logic [31:0]       iter_cnt,
    output logic              random_run,
    output distance_command_t or_distance_com,
    output logic              or_metropolis_run,
    output logic              or_replica_run,
    output logic              or_exchange_run,
    output distance_command_t tw_distance_com,
    output logic              tw_metropolis_run,
    output logic              tw_replica_run,
    output logic              tw_exchange_run,
    output logic              exchange_bank,
    output logic              exp_init,
    output logic              exp_run
);

    seq_state_t state;
    seq_state_t next_state;
    logic       timer_load;
    phase_cnt_t timer_value;
    logic       timer_expire;
    logic       stop_pend;
    logic       repl_en;
    logic       last_iter;

    phase_timer u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

`ifdef REPLICA_INTERVAL_EN
    logic [31:0] repl_mask;
    assign repl_mask = (32'd1 << replica_interval) - 32'd1;
    assign repl_en   = ((iter_cnt & repl_mask) == 32'd0);
`else
    logic unused_replica_interval;
    assign unused_replica_interval = ^replica_interval;
    assign repl_en = 1'b1;
`endif

    assign last_iter   = ((iter_cnt + 32'd1) == iter_num);
    assign timer_value = phase_len_m1(next_state, DIST_CYC, EXP_CYC, EXCH_CYC);

    // Next phase and timer load: advance when the shared timer expires.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // through this block leaves it unassigned (which would infer a latch).
        next_state = state;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                if (start && (iter_num != 32'd0)) begin
                    next_state = RAND;
                    timer_load = 1'b1;
                end
            end
            NEXT: begin
                // done was decided on entry to NEXT; it selects the exit.
                next_state = done ? IDLE : RAND;
                timer_load = !done;
            end
            default: begin
                if (timer_expire) begin
                    next_state = seq_next(state);
                    timer_load = 1'b1;
                end
            end
        endcase
    end

    // State, run bookkeeping and strobes, all registered from next_state so
    // each strobe lines up exactly with the phase it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            iter_cnt          <= '0;
            stop_pend         <= 1'b0;
            exchange_bank     <= 1'b0;
            exp_init          <= 1'b0;
            exp_run           <= 1'b0;
            random_run        <= 1'b0;
            or_distance_com   <= '0;
            or_metropolis_run <= 1'b0;
            or_replica_run    <= 1'b0;
            or_exchange_run   <= 1'b0;
            tw_distance_com   <= '0;
            tw_metropolis_run <= 1'b0;
            tw_replica_run    <= 1'b0;
            tw_exchange_run   <= 1'b0;
        end else begin
            state    <= next_state;
            exp_init <= 1'b0;
            done     <= 1'b0;

            // A stop is remembered until the run ends; a stop sampled on the
            // edge into NEXT is seen directly by the end-of-run test below.
            if (next_state == IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && (state != IDLE)) begin
                stop_pend <= 1'b1;
            end

            // Start is only accepted while idle.
            if ((state == IDLE) && start) begin
                iter_cnt <= '0;
                if (iter_num == 32'd0) begin
                    done <= 1'b1;
                end else begin
                    busy     <= 1'b1;
                    exp_init <= 1'b1;
                end
            end

            // Entering NEXT closes an iteration.
            if ((state == TW_EXCH) && timer_expire) begin
                iter_cnt      <= iter_cnt + 32'd1;
                exchange_bank <= ~exchange_bank;
                if (last_iter || stop_pend || stop) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end

            // RAND strobes on its second cycle only (not the entry cycle).
            random_run           <= (next_state == RAND) && !timer_load;
            or_distance_com.run  <= (next_state == OR_DIST);
            or_distance_com.init <= (next_state == OR_DIST) && timer_load;
            tw_distance_com.run  <= (next_state == TW_DIST);
            tw_distance_com.init <= (next_state == TW_DIST) && timer_load;
            exp_run              <= (next_state == OR_EXP) || (next_state == TW_EXP);
            or_metropolis_run    <= (next_state == OR_METRO);
            tw_metropolis_run    <= (next_state == TW_METRO);
            or_replica_run       <= (next_state == OR_REPL) && repl_en;
            tw_replica_run       <= (next_state == TW_REPL) && repl_en;
            or_exchange_run      <= (next_state == OR_EXCH);
            tw_exchange_run      <= (next_state == TW_EXCH);
        end
    end

endmodule

// File: tb/tb_anneal_sequencer.sv
// Scoreboard bench for anneal_sequencer at default phase lengths (4/3/2).
// Stimulus pushes expected per-cycle traces and end-of-run records; a
// monitor on the falling edge pops and compares them.
module tb_anneal_sequencer;
    import replica_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [31:0]       iter_num;
    logic [3:0]        replica_interval;
    logic              busy;
    logic              done;
    logic [31:0]       iter_cnt;
    logic              random_run;
    distance_command_t or_distance_com;
    logic              or_metropolis_run;
    logic              or_replica_run;
    logic              or_exchange_run;
    distance_command_t tw_distance_com;
    logic              tw_metropolis_run;
    logic              tw_replica_run;
    logic              tw_exchange_run;
    logic              exchange_bank;
    logic              exp_init;
    logic              exp_run;

    anneal_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .iter_num          (iter_num),
        .replica_interval  (replica_interval),
        .busy              (busy),
        .done              (done),
        .iter_cnt          (iter_cnt),
        .random_run        (random_run),
        .or_distance_com   (or_distance_com),
        .or_metropolis_run (or_metropolis_run),
        .or_replica_run    (or_replica_run),
        .or_exchange_run   (or_exchange_run),
        .tw_distance_com   (tw_distance_com),
        .tw_metropolis_run (tw_metropolis_run),
        .tw_replica_run    (tw_replica_run),
        .tw_exchange_run   (tw_exchange_run),
        .exchange_bank     (exchange_bank),
        .exp_init          (exp_init),
        .exp_run           (exp_run)
    );

    always #5 clk = ~clk;

    // Observed signal vector; bit map:
    // 14 busy 13 done 12 exp_init 11 exp_run 10 random 9 or_init 8 or_run
    // 7 or_metro 6 or_repl 5 or_exch 4 tw_init 3 tw_run 2 tw_metro 1 tw_repl 0 tw_exch
    logic [14:0] obs;
    assign obs = {busy, done, exp_init, exp_run, random_run,
                  or_distance_com.init, or_distance_com.run, or_metropolis_run,
                  or_replica_run, or_exchange_run,
                  tw_distance_com.init, tw_distance_com.run, tw_metropolis_run,
                  tw_replica_run, tw_exchange_run};

    typedef struct {
        logic [14:0] sig;
        logic        bank;
        logic [31:0] cnt;
    } trace_t;

    typedef struct {
        int          lat;
        logic [31:0] cnt;
        logic        bank;
        int          n_init;
        int          n_rand;
        int          n_orr;
        int          n_twr;
    } done_rec_t;

    trace_t    trace_q[$];
    done_rec_t done_q[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  cnt_clear = 1'b0;
    bit  model_bank = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-derived single-iteration waveform, cycle 0 = first cycle after
    // the start edge: random 1, or_dist 2-5, exp 6-8, metro 9, repl 10,
    // exch 11-12, two-opt half 13-23, done 24.
    function automatic logic [14:0] iter1_sig(input int c);
        logic [14:0] s;
        s     = '0;
        s[14] = (c <= 23);
        s[13] = (c == 24);
        s[12] = (c == 0);
        s[11] = ((c >= 6) && (c <= 8)) || ((c >= 17) && (c <= 19));
        s[10] = (c == 1);
        s[9]  = (c == 2);
        s[8]  = (c >= 2) && (c <= 5);
        s[7]  = (c == 9);
        s[6]  = (c == 10);
        s[5]  = (c == 11) || (c == 12);
        s[4]  = (c == 13);
        s[3]  = (c >= 13) && (c <= 16);
        s[2]  = (c == 20);
        s[1]  = (c == 21);
        s[0]  = (c == 22) || (c == 23);
        return s;
    endfunction

    // Monitor: compares traces every cycle and run records on each done.
    int        mon_cyc = 0;
    int        m_init = 0, m_rand = 0, m_orr = 0, m_twr = 0, m_overlap = 0;
    trace_t    mon_t;
    done_rec_t mon_r;
    logic [10:0] strobes;

    initial begin
        forever begin
            @(negedge clk);
            if (trace_q.size() > 0) begin
                mon_t = trace_q.pop_front();
                check("trace_sig", obs, mon_t.sig);
                check("trace_bank", exchange_bank, mon_t.bank);
                check("trace_iter_cnt", iter_cnt, mon_t.cnt);
            end
            if (cnt_clear) begin
                cnt_clear = 1'b0;
                mon_cyc   = 0;
                m_init    = 0;
                m_rand    = 0;
                m_orr     = 0;
                m_twr     = 0;
                m_overlap = 0;
            end else begin
                mon_cyc++;
            end
            if (exp_init === 1'b1)       m_init++;
            if (random_run === 1'b1)     m_rand++;
            if (or_replica_run === 1'b1) m_orr++;
            if (tw_replica_run === 1'b1) m_twr++;
            strobes = {obs[11], obs[10], obs[8:5], obs[3:0], 1'b0};
            if ($countones(strobes) > 1) m_overlap++;
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done high with no run expected at %0t", $time);
                end else begin
                    mon_r = done_q.pop_front();
                    check("done_latency", 64'(mon_cyc), 64'(mon_r.lat));
                    check("done_iter_cnt", iter_cnt, mon_r.cnt);
                    check("done_bank", exchange_bank, mon_r.bank);
                    check("done_busy_low", busy, 1'b0);
                    check("exp_init_pulses", 64'(m_init), 64'(mon_r.n_init));
                    check("random_pulses", 64'(m_rand), 64'(mon_r.n_rand));
                    check("or_replica_pulses", 64'(m_orr), 64'(mon_r.n_orr));
                    check("tw_replica_pulses", 64'(m_twr), 64'(mon_r.n_twr));
                    check("strobe_overlap", 64'(m_overlap), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns #1 into cycle 0 of the run.
    task automatic issue_start(input logic [31:0] n, input logic [3:0] ri);
        iter_num         = n;
        replica_interval = ri;
        start            = 1'b1;
        tick();
        start     = 1'b0;
        cnt_clear = 1'b1;
    endtask

    task automatic wait_done(input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; (i < limit) && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, limit);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_repl;
        reset            = 1'b1;
        start            = 1'b0;
        stop             = 1'b0;
        iter_num         = '0;
        replica_interval = '0;
        tick();
        trace_q.push_back('{sig: 15'd0, bank: 1'b0, cnt: 32'd0});
        tick();
        reset = 1'b0;
        tick();
        model_bank = 1'b0;

        // Single iteration: exact cycle-by-cycle waveform.
        issue_start(32'd1, 4'd0);
        for (int c = 0; c <= 24; c++) begin
            trace_q.push_back('{sig: iter1_sig(c),
                                bank: (c == 24) ? ~model_bank : model_bank,
                                cnt: (c == 24) ? 32'd1 : 32'd0});
        end
        model_bank ^= 1'b1;
        done_q.push_back('{lat: 24, cnt: 32'd1, bank: model_bank,
                           n_init: 1, n_rand: 1, n_orr: 1, n_twr: 1});
        wait_done(40, "iter1_done");

        // Reset during TW_EXCH (cycles 22-23): outputs clear, no done.
        issue_start(32'd5, 4'd0);
        repeat (22) tick();
        trace_q.push_back('{sig: 15'b100_0000_0000_0001, bank: model_bank, cnt: 32'd0});
        reset = 1'b1;
        tick();
        trace_q.push_back('{sig: 15'd0, bank: 1'b0, cnt: 32'd0});
        model_bank = 1'b0;
        reset = 1'b0;
        repeat (4) tick();

        // Three iterations, with a start pulse mid-run that must be ignored.
        issue_start(32'd3, 4'd0);
        model_bank ^= 1'b1;
        done_q.push_back('{lat: 74, cnt: 32'd3, bank: model_bank,
                           n_init: 1, n_rand: 3, n_orr: 3, n_twr: 3});
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, "iter3_done");

        // Stop during iteration 2 OR_EXP (cycles 31-33): ends after iteration 2.
        issue_start(32'd100, 4'd0);
        done_q.push_back('{lat: 49, cnt: 32'd2, bank: model_bank,
                           n_init: 1, n_rand: 2, n_orr: 2, n_twr: 2});
        repeat (32) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(100, "stop_exp_done");

        // Stop sampled on the edge into NEXT still ends the run there.
        issue_start(32'd100, 4'd0);
        model_bank ^= 1'b1;
        done_q.push_back('{lat: 24, cnt: 32'd1, bank: model_bank,
                           n_init: 1, n_rand: 1, n_orr: 1, n_twr: 1});
        repeat (23) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(60, "stop_next_done");

        // iter_num = 0: done in cycle 0, busy never rises, no strobes.
        issue_start(32'd0, 4'd0);
        trace_q.push_back('{sig: 15'b010_0000_0000_0000, bank: model_bank, cnt: 32'd0});
        trace_q.push_back('{sig: 15'd0, bank: model_bank, cnt: 32'd0});
        done_q.push_back('{lat: 0, cnt: 32'd0, bank: model_bank,
                           n_init: 0, n_rand: 0, n_orr: 0, n_twr: 0});
        wait_done(5, "zero_done");

        // Eight iterations, replica_interval = 2: replica test in iterations
        // 0 and 4 only when the feature is built in; timing unchanged.
`ifdef REPLICA_INTERVAL_EN
        n_repl = 2;
`else
        n_repl = 8;
`endif
        issue_start(32'd8, 4'd2);
        done_q.push_back('{lat: 199, cnt: 32'd8, bank: model_bank,
                           n_init: 1, n_rand: 8, n_orr: n_repl, n_twr: n_repl});
        wait_done(260, "iter8_done");

        check("trace_q_drained", 64'(trace_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anneal_sequencer.md
Name: anneal_sequencer

Overview:
- Upstream command generator for the replica node array.
- Steps one annealing iteration at a time through random draw, the or-opt half and the two-opt half.
- Each half runs delta distance, exp evaluation, metropolis test, replica exchange test and ordering exchange.
- Drives the shared command strobes broadcast to every node, toggles exchange_bank per iteration, and reports progress to the host register block.

Parameters:
- DIST_CYC, 4, cycles distance_com.run stays high per half-iteration (1..255)
- EXP_CYC, 3, cycles exp_run stays high per half-iteration (1..255)
- EXCH_CYC, 2, cycles exchange_run stays high per half-iteration (1..255)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a run when idle
- stop  input  1  pulse; finish current iteration, then end run
- iter_num  input  32  iterations to execute; 0 means none
- replica_interval  input  4  log2 replica-exchange period (feature only)
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at run end
- iter_cnt  output  32  completed iterations this run
- random_run  output  1  random-draw strobe
- or_distance_com  output  distance_command_t  or-opt delta-distance command
- or_metropolis_run  output  1  or-opt metropolis strobe
- or_replica_run  output  1  or-opt replica-test strobe
- or_exchange_run  output  1  or-opt exchange enable
- tw_distance_com  output  distance_command_t  two-opt delta-distance command
- tw_metropolis_run  output  1  two-opt metropolis strobe
- tw_replica_run  output  1  two-opt replica-test strobe
- tw_exchange_run  output  1  two-opt exchange enable
- exchange_bank  output  1  ordering bank select
- exp_init  output  1  exp unit init pulse
- exp_run  output  1  exp unit enable

Behaviour:
- All outputs are registered; no combinational path from inputs.
- Reset: state IDLE; all outputs 0, including exchange_bank=0 and iter_cnt=0.
- Reset asserted mid-run aborts immediately; no done pulse.
- States: IDLE, RAND, OR_DIST, OR_EXP, OR_METRO, OR_REPL, OR_EXCH, TW_DIST, TW_EXP, TW_METRO, TW_REPL, TW_EXCH, NEXT.
- IDLE + start:
  - iter_num=0: done pulses next cycle, busy stays 0.
  - Otherwise: busy=1, iter_cnt=0, exp_init=1 for one cycle, go to RAND.
- start while busy is ignored.
- RAND: random_run=1 for 1 cycle.
- x_DIST: x_distance_com.run=1 for DIST_CYC cycles; x_distance_com.init=1 on the first of those cycles only.
- x_EXP: exp_run=1 for EXP_CYC cycles.
- x_METRO: x_metropolis_run=1, 1 cycle.
- x_REPL: x_replica_run=1, 1 cycle.
- x_EXCH: x_exchange_run=1 for EXCH_CYC cycles.
- Phase order: OR_* then TW_*, then NEXT.
- NEXT (1 cycle):
  - exchange_bank toggles; iter_cnt increments.
  - If iter_cnt+1==iter_num or a stop is pending: done=1, busy=0, go to IDLE.
  - Otherwise go to RAND.
- Iteration length = 3 + 2*(DIST_CYC+EXP_CYC+EXCH_CYC+2) cycles; 25 at defaults.
- Strobes are mutually exclusive, except the init field coincides with run.
- stop is latched into a pending flag. It is honoured only in NEXT and cleared on IDLE entry. A stop at NEXT itself counts.
- Phase duration uses one shared 8-bit down-counter, loaded with N-1 on state entry; advance when it reaches 0.
- iter_cnt wraps at 2^32 without side effect.
- exchange_bank persists across runs; only reset clears it.

Optional Feature:
- REPLICA_INTERVAL_EN
  - Defined: x_REPL asserts x_replica_run only when iter_cnt[replica_interval-1:0]==0 (always when replica_interval=0). The state is still visited, so timing is unchanged.
  - Undefined: replica_run every iteration; the replica_interval input is ignored.

Decomposition:
- replica_pkg, existing:
  - distance_command_t (fields init, run)
  - seq_state_t enum of the 13 states
  - PHASE_CNT_W=8 constant
- Sub-module phase_timer:
  - Loadable 8-bit down-counter with load, value and expire ports.
  - Instantiated once.

Test Plan:
- reset, then start with iter_num=1 at defaults:
  - random_run at cycle 1.
  - or_distance_com.run cycles 2-5, init cycle 2 only.
  - exp_run 6-8, or_metropolis 9, or_replica 10, or_exchange 11-12.
  - tw_* mirror at 13-23.
  - done at 24; exchange_bank=1; iter_cnt=1.
- iter_num=3 -> done after 75 cycles; exchange_bank toggles 3 times, ending at 1; exp_init pulses once.
- iter_num=100, stop pulsed during iteration 2 OR_EXP -> done at end of iteration 2; iter_cnt=2.
- reset asserted during TW_EXCH -> next cycle all outputs 0 and no done; a subsequent start runs normally.
- iter_num=0 -> done one cycle after start, no strobes; start repeated while busy -> ignored.
- REPLICA_INTERVAL_EN, replica_interval=2, iter_num=8 -> or_/tw_replica_run only in iterations 0 and 4; total cycle count unchanged (200).
